mips_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage MIPS pipeline (fetch, issue, ex, mem, wb).
- Drives the active-low-enable stall inputs and clr inputs of the fetch-issue and issue-ex pipeline registers.
- Generates operand forwarding selects for the ex stage and for the issue-stage branch comparator.
- Sequences the multi-cycle multiply/divide unit (MDU) with a busy state machine and latency counter, so hi/lo consumers stall until the result is valid.

---
 rtl/mips_pipe_pkg.sv | 26 ++
 rtl/mips_hazard_ctrl_if.sv | 57 +++++
 rtl/mips_mdu_seq.sv | 64 ++++++
 rtl/mips_hazard_ctrl.sv | 75 +++++++
 tb/tb_mips_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// mips_pipe_pkg : forwarding-select and MDU state encodings shared by the
//                 hazard controller and its sub-blocks.
// Revision      : 1.0
// ============================================================================
package mips_pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int MDU_CNT_W = 6;

   typedef enum logic [0:0] {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   // Register 0 is hard-wired to zero, so it can never create a dependency.
   function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// mips_hazard_ctrl_if : pipeline-to-hazard-controller signal bundle.
// Revision            : 1.0
// ============================================================================
interface mips_hazard_ctrl_if;
   logic [4:0] rs_iss_i;
   logic [4:0] rt_iss_i;
   logic [4:0] rs_ex_i;
   logic [4:0] rt_ex_i;
   logic [4:0] dst_ex_i;
   logic [4:0] dst_mem_i;
   logic [4:0] dst_wb_i;
   logic       reg_wr_ex_i;
   logic       reg_wr_mem_i;
   logic       reg_wr_wb_i;
   logic       mem_to_reg_ex_i;
   logic       mem_to_reg_mem_i;
   logic       branch_iss_i;
   logic       pc_redirect_i;
   logic       mdu_op_iss_i;
   logic       mdu_start_ex_i;
   logic       mdu_is_div_ex_i;
   logic       hilo_rd_iss_i;
   logic       stall_fetch_o;
   logic       stall_iss_o;
   logic       clr_iss_o;
   logic       clr_ex_o;
   logic [1:0] fwd_a_ex_o;
   logic [1:0] fwd_b_ex_o;
   logic       fwd_a_iss_o;
   logic       fwd_b_iss_o;
   logic       mdu_busy_o;

   modport master (
      output rs_iss_i, rt_iss_i, rs_ex_i, rt_ex_i,
      output dst_ex_i, dst_mem_i, dst_wb_i,
      output reg_wr_ex_i, reg_wr_mem_i, reg_wr_wb_i,
      output mem_to_reg_ex_i, mem_to_reg_mem_i,
      output branch_iss_i, pc_redirect_i,
      output mdu_op_iss_i, mdu_start_ex_i, mdu_is_div_ex_i, hilo_rd_iss_i,
      input  stall_fetch_o, stall_iss_o, clr_iss_o, clr_ex_o,
      input  fwd_a_ex_o, fwd_b_ex_o, fwd_a_iss_o, fwd_b_iss_o, mdu_busy_o
   );

   modport slave (
      input  rs_iss_i, rt_iss_i, rs_ex_i, rt_ex_i,
      input  dst_ex_i, dst_mem_i, dst_wb_i,
      input  reg_wr_ex_i, reg_wr_mem_i, reg_wr_wb_i,
      input  mem_to_reg_ex_i, mem_to_reg_mem_i,
      input  branch_iss_i, pc_redirect_i,
      input  mdu_op_iss_i, mdu_start_ex_i, mdu_is_div_ex_i, hilo_rd_iss_i,
      output stall_fetch_o, stall_iss_o, clr_iss_o, clr_ex_o,
      output fwd_a_ex_o, fwd_b_ex_o, fwd_a_iss_o, fwd_b_iss_o, mdu_busy_o
   );
endinterface
`default_nettype wire

// File: rtl/mips_mdu_seq.sv
`default_nettype none
// ============================================================================
// mips_mdu_seq : multiply/divide busy sequencer; busy_o stays high for the
//                full MUL_LAT or DIV_LAT cycles after a start.
// Revision     : 1.0
// ============================================================================
module mips_mdu_seq
   import mips_pipe_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
)(
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic is_div_i,
   output logic busy_o
);

   localparam logic [MDU_CNT_W-1:0] MUL_CNT = MDU_CNT_W'(MUL_LAT - 1);
   localparam logic [MDU_CNT_W-1:0] DIV_CNT = MDU_CNT_W'(DIV_LAT - 1);

   mdu_state_e             state_q, state_d;
   logic [MDU_CNT_W-1:0]   count_q, count_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MDU_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // A start arriving while BUSY is dropped; issue-side stalling keeps it from happening.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         MDU_IDLE: begin
            if (start_i) begin
               state_d = MDU_BUSY;
               count_d = is_div_i ? DIV_CNT : MUL_CNT;
            end
         end
         MDU_BUSY: begin
            if (count_q == '0) begin
               state_d = MDU_IDLE;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         default: begin
            state_d = MDU_IDLE;
            count_d = '0;
         end
      endcase
   end

   assign busy_o = (state_q == MDU_BUSY);

endmodule
`default_nettype wire

// File: rtl/mips_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// mips_hazard_ctrl : stall/flush, operand forwarding and MDU sequencing for
//                    the 5-stage MIPS pipeline.
// Revision         : 1.0
// ============================================================================
module mips_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
)(
   input  logic              clk,
   input  logic              reset,
   mips_hazard_ctrl_if.slave hz
);

   logic w_lu;
   logic w_bs;
   logic w_ms;
   logic w_stall;
   logic w_mdu_busy;

   // Mem-stage result is younger than wb, so it wins when both match.
   function automatic logic [1:0] ex_fwd_sel(input logic [4:0] src);
      if (hz.reg_wr_mem_i && reg_match(src, hz.dst_mem_i)) begin
         return FWD_MEM;
      end else if (hz.reg_wr_wb_i && reg_match(src, hz.dst_wb_i)) begin
         return FWD_WB;
      end
      return FWD_RF;
   endfunction

   function automatic logic iss_fwd(input logic [4:0] src);
      return hz.branch_iss_i && hz.reg_wr_mem_i && !hz.mem_to_reg_mem_i &&
             reg_match(src, hz.dst_mem_i);
   endfunction

   mips_mdu_seq #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_mdu_seq (
      .clk      (clk),
      .reset    (reset),
      .start_i  (hz.mdu_start_ex_i),
      .is_div_i (hz.mdu_is_div_ex_i),
      .busy_o   (w_mdu_busy)
   );

   assign w_lu = hz.mem_to_reg_ex_i &&
                 (reg_match(hz.rs_iss_i, hz.dst_ex_i) || reg_match(hz.rt_iss_i, hz.dst_ex_i));

   // The branch comparator sits in issue, so an ex-stage ALU result or a
   // mem-stage load is not yet available to it.
   assign w_bs = hz.branch_iss_i &&
                 ((hz.reg_wr_ex_i &&
                   (reg_match(hz.rs_iss_i, hz.dst_ex_i) || reg_match(hz.rt_iss_i, hz.dst_ex_i))) ||
                  (hz.mem_to_reg_mem_i &&
                   (reg_match(hz.rs_iss_i, hz.dst_mem_i) || reg_match(hz.rt_iss_i, hz.dst_mem_i))));

   assign w_ms    = w_mdu_busy && (hz.hilo_rd_iss_i || hz.mdu_op_iss_i);
   assign w_stall = w_lu || w_bs || w_ms;

   assign hz.stall_fetch_o = w_stall;
   assign hz.stall_iss_o   = w_stall;
   assign hz.clr_ex_o      = w_stall;
   assign hz.clr_iss_o     = hz.pc_redirect_i && !w_stall;
   assign hz.fwd_a_ex_o    = ex_fwd_sel(hz.rs_ex_i);
   assign hz.fwd_b_ex_o    = ex_fwd_sel(hz.rt_ex_i);
   assign hz.fwd_a_iss_o   = iss_fwd(hz.rs_iss_i);
   assign hz.fwd_b_iss_o   = iss_fwd(hz.rt_iss_i);
   assign hz.mdu_busy_o    = w_mdu_busy;

endmodule
`default_nettype wire

// File: tb/tb_mips_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mips_hazard_ctrl : directed + randomized self-checking bench for
//                       mips_hazard_ctrl against a behavioural model.
// Revision            : 1.0
// ============================================================================
module tb_mips_hazard_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mips_hazard_ctrl_if h  ();
   mips_hazard_ctrl_if h1 ();

   mips_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (h.slave)
   );

   mips_hazard_ctrl #(.MUL_LAT(1), .DIV_LAT(32)) dut1 (
      .clk   (clk),
      .reset (reset),
      .hz    (h1.slave)
   );

   int checks = 0;
   int errors = 0;
   int rem0   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      h.rs_iss_i = '0; h.rt_iss_i = '0; h.rs_ex_i = '0; h.rt_ex_i = '0;
      h.dst_ex_i = '0; h.dst_mem_i = '0; h.dst_wb_i = '0;
      h.reg_wr_ex_i = 0; h.reg_wr_mem_i = 0; h.reg_wr_wb_i = 0;
      h.mem_to_reg_ex_i = 0; h.mem_to_reg_mem_i = 0;
      h.branch_iss_i = 0; h.pc_redirect_i = 0; h.mdu_op_iss_i = 0;
      h.mdu_start_ex_i = 0; h.mdu_is_div_ex_i = 0; h.hilo_rd_iss_i = 0;
      h1.rs_iss_i = '0; h1.rt_iss_i = '0; h1.rs_ex_i = '0; h1.rt_ex_i = '0;
      h1.dst_ex_i = '0; h1.dst_mem_i = '0; h1.dst_wb_i = '0;
      h1.reg_wr_ex_i = 0; h1.reg_wr_mem_i = 0; h1.reg_wr_wb_i = 0;
      h1.mem_to_reg_ex_i = 0; h1.mem_to_reg_mem_i = 0;
      h1.branch_iss_i = 0; h1.pc_redirect_i = 0; h1.mdu_op_iss_i = 0;
      h1.mdu_start_ex_i = 0; h1.mdu_is_div_ex_i = 0; h1.hilo_rd_iss_i = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall_fetch"}, int'(h.stall_fetch_o), 0);
      chk({tag, "_stall_iss"},   int'(h.stall_iss_o),   0);
      chk({tag, "_clr_iss"},     int'(h.clr_iss_o),     0);
      chk({tag, "_clr_ex"},      int'(h.clr_ex_o),      0);
      chk({tag, "_fwd_a_ex"},    int'(h.fwd_a_ex_o),    0);
      chk({tag, "_fwd_b_ex"},    int'(h.fwd_b_ex_o),    0);
      chk({tag, "_fwd_a_iss"},   int'(h.fwd_a_iss_o),   0);
      chk({tag, "_fwd_b_iss"},   int'(h.fwd_b_iss_o),   0);
      chk({tag, "_mdu_busy"},    int'(h.mdu_busy_o),    0);
   endtask

   // Model of the MDU: cycles of latency still outstanding.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rem0 <= 0;
      end else if (rem0 > 0) begin
         rem0 <= rem0 - 1;
      end else if (h.mdu_start_ex_i) begin
         rem0 <= h.mdu_is_div_ex_i ? 32 : 4;
      end
   end

   function automatic bit dep(input logic [4:0] src, input logic [4:0] dst);
      return (src != 0) && (src == dst);
   endfunction

   function automatic int fwd_exp(input logic [4:0] src);
      if (h.reg_wr_mem_i && dep(src, h.dst_mem_i)) return 2;
      if (h.reg_wr_wb_i && dep(src, h.dst_wb_i)) return 1;
      return 0;
   endfunction

   always @(negedge clk) begin
      bit busy, lu, bs, ms, st;
      busy = (rem0 > 0);
      lu = h.mem_to_reg_ex_i && (dep(h.rs_iss_i, h.dst_ex_i) || dep(h.rt_iss_i, h.dst_ex_i));
      bs = h.branch_iss_i &&
           ((h.reg_wr_ex_i && (dep(h.rs_iss_i, h.dst_ex_i) || dep(h.rt_iss_i, h.dst_ex_i))) ||
            (h.mem_to_reg_mem_i && (dep(h.rs_iss_i, h.dst_mem_i) || dep(h.rt_iss_i, h.dst_mem_i))));
      ms = busy && (h.hilo_rd_iss_i || h.mdu_op_iss_i);
      st = lu || bs || ms;
      chk("m_stall_fetch", int'(h.stall_fetch_o), int'(st));
      chk("m_stall_iss",   int'(h.stall_iss_o),   int'(st));
      chk("m_clr_ex",      int'(h.clr_ex_o),      int'(st));
      chk("m_clr_iss",     int'(h.clr_iss_o),     int'(h.pc_redirect_i && !st));
      chk("m_fwd_a_ex",    int'(h.fwd_a_ex_o),    fwd_exp(h.rs_ex_i));
      chk("m_fwd_b_ex",    int'(h.fwd_b_ex_o),    fwd_exp(h.rt_ex_i));
      chk("m_fwd_a_iss",   int'(h.fwd_a_iss_o),
          int'(h.branch_iss_i && h.reg_wr_mem_i && !h.mem_to_reg_mem_i && dep(h.rs_iss_i, h.dst_mem_i)));
      chk("m_fwd_b_iss",   int'(h.fwd_b_iss_o),
          int'(h.branch_iss_i && h.reg_wr_mem_i && !h.mem_to_reg_mem_i && dep(h.rt_iss_i, h.dst_mem_i)));
      chk("m_mdu_busy",    int'(h.mdu_busy_o),    int'(busy));
      if (h.mdu_start_ex_i && busy) chk("start_while_busy", 1, 0);
   end

   initial begin
      int nb, ns;
      idle_inputs();
      #1 reset = 1'b1;
      #1 chk_all_zero("reset");
      step();
      step();
      reset = 1'b0;

      // Forwarding priority
      h.dst_mem_i = 5; h.dst_wb_i = 5; h.rs_ex_i = 5; h.reg_wr_mem_i = 1; h.reg_wr_wb_i = 1;
      sample(); chk("fwd_pri_mem", int'(h.fwd_a_ex_o), 2);
      step(); h.reg_wr_mem_i = 0;
      sample(); chk("fwd_pri_wb", int'(h.fwd_a_ex_o), 1);
      step(); h.rs_ex_i = 0;
      sample(); chk("fwd_pri_r0", int'(h.fwd_a_ex_o), 0);

      // Load-use: one stall cycle, then the load has moved to mem
      step(); idle_inputs();
      h.mem_to_reg_ex_i = 1; h.dst_ex_i = 8; h.rt_iss_i = 8;
      sample(); chk("lu_stall", int'(h.stall_iss_o), 1);
      chk("lu_stall_fetch", int'(h.stall_fetch_o), 1);
      chk("lu_clr_ex", int'(h.clr_ex_o), 1);
      step(); h.mem_to_reg_ex_i = 0; h.dst_ex_i = 0;
      h.mem_to_reg_mem_i = 1; h.reg_wr_mem_i = 1; h.dst_mem_i = 8;
      sample(); chk("lu_release", int'(h.stall_iss_o), 0);
      step(); idle_inputs();
      h.mem_to_reg_ex_i = 1; h.dst_ex_i = 0; h.rt_iss_i = 0;
      sample(); chk("lu_r0", int'(h.stall_iss_o), 0);

      // Branch on ALU producer in ex, then in mem
      step(); idle_inputs();
      h.branch_iss_i = 1; h.rs_iss_i = 3; h.reg_wr_ex_i = 1; h.dst_ex_i = 3; h.pc_redirect_i = 1;
      sample(); chk("br_stall", int'(h.stall_iss_o), 1);
      chk("br_clr_iss", int'(h.clr_iss_o), 0);
      step(); h.reg_wr_ex_i = 0; h.dst_ex_i = 0; h.reg_wr_mem_i = 1; h.dst_mem_i = 3;
      sample(); chk("br_fwd_iss", int'(h.fwd_a_iss_o), 1);
      chk("br_nostall", int'(h.stall_iss_o), 0);
      chk("br_redirect", int'(h.clr_iss_o), 1);

      // Divide with mfhi held in issue
      step(); idle_inputs();
      h.mdu_start_ex_i = 1; h.mdu_is_div_ex_i = 1;
      step(); h.mdu_start_ex_i = 0; h.mdu_is_div_ex_i = 0; h.hilo_rd_iss_i = 1;
      nb = 0; ns = 0;
      for (int i = 0; i < 100; i++) begin
         sample();
         if (h.stall_iss_o) ns++;
         if (h.mdu_busy_o) nb++;
         if (!h.stall_iss_o && !h.mdu_busy_o) break;
      end
      chk("div_busy_cycles", nb, 32);
      chk("div_stall_cycles", ns, 32);

      // MUL_LAT=1 instance: one busy cycle, one stall for a back-to-back mult
      step(); idle_inputs();
      h1.mdu_start_ex_i = 1;
      step(); h1.mdu_start_ex_i = 0; h1.mdu_op_iss_i = 1;
      nb = 0; ns = 0;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (h1.stall_iss_o) ns++;
         if (h1.mdu_busy_o) nb++;
         if (!h1.stall_iss_o && !h1.mdu_busy_o) break;
      end
      chk("mul1_busy_cycles", nb, 1);
      chk("mul1_stall_cycles", ns, 1);

      // Asynchronous reset in the middle of a divide
      step(); idle_inputs();
      h.mdu_start_ex_i = 1; h.mdu_is_div_ex_i = 1;
      step(); h.mdu_start_ex_i = 0; h.mdu_is_div_ex_i = 0;
      for (int i = 0; i < 10; i++) step();
      chk("pre_rst_busy", int'(h.mdu_busy_o), 1);
      #2 reset = 1'b1;
      #1 chk("async_rst_busy", int'(h.mdu_busy_o), 0);
      idle_inputs();
      #0 chk_all_zero("async_rst");
      step(); reset = 1'b0;
      h.mdu_start_ex_i = 1;
      step(); h.mdu_start_ex_i = 0;
      nb = 0;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (h.mdu_busy_o) nb++;
         else break;
      end
      chk("mul_after_rst", nb, 4);

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         step();
         h.rs_iss_i = 5'($urandom_range(0, 7)); h.rt_iss_i = 5'($urandom_range(0, 7));
         h.rs_ex_i  = 5'($urandom_range(0, 7)); h.rt_ex_i  = 5'($urandom_range(0, 7));
         h.dst_ex_i = 5'($urandom_range(0, 7)); h.dst_mem_i = 5'($urandom_range(0, 7));
         h.dst_wb_i = 5'($urandom_range(0, 7));
         h.reg_wr_ex_i = 1'($urandom); h.reg_wr_mem_i = 1'($urandom); h.reg_wr_wb_i = 1'($urandom);
         h.mem_to_reg_ex_i = 1'($urandom); h.mem_to_reg_mem_i = 1'($urandom);
         h.branch_iss_i = 1'($urandom); h.pc_redirect_i = 1'($urandom);
         h.mdu_op_iss_i = 1'($urandom); h.hilo_rd_iss_i = 1'($urandom);
         h.mdu_start_ex_i = (rem0 == 0) && ($urandom_range(0, 7) == 0);
         h.mdu_is_div_ex_i = ($urandom_range(0, 3) == 0);
      end

      step(); idle_inputs();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
